// File: rtl/ika9958_pkg.sv
// Shared types and the modulo-line target arithmetic for the horizontal dot-timing block.
package ika9958_pkg;

  localparam int HCNT_W = 9;

  typedef logic [HCNT_W-1:0] hcnt_t;
  typedef logic signed [3:0] hadj_t;

  // Shift a decode point by a signed adjust and wrap it back into 0..htotal-1.
  function automatic hcnt_t hwrap(input hcnt_t base, input hadj_t adj, input hcnt_t htotal);
    logic signed [HCNT_W:0] sum;
    logic signed [HCNT_W:0] tot;
    tot = signed'({1'b0, htotal});
    sum = signed'({1'b0, base}) + signed'((HCNT_W + 1)'(adj));
    if (sum < 0) begin
      sum = sum + tot;
    end else if (sum >= tot) begin
      sum = sum - tot;
    end
    return hcnt_t'(sum[HCNT_W-1:0]);
  endfunction

endpackage

// File: rtl/ika9958_hdot_cmp.sv
// One decode point: registered one-dot strobe for count == BASE (+ adjust when IKA9958_HADJ_EN).
module ika9958_hdot_cmp
  import ika9958_pkg::*;
#(
  parameter int BASE   = 0,
  parameter int HTOTAL = 342
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  cen_i,
  input  hadj_t adj_d_i,
  input  hcnt_t cnt_d_i,
  output logic  strobe_o
);

  hcnt_t target;
  logic  strobe_q;

`ifdef IKA9958_HADJ_EN
  assign target = hwrap(hcnt_t'(BASE), adj_d_i, hcnt_t'(HTOTAL));
`else
  logic unused_adj;
  assign unused_adj = ^adj_d_i;
  assign target     = hcnt_t'(BASE);
`endif

  // Compared against the next count so the strobe lines up with the dot it names.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      strobe_q <= (hcnt_t'(BASE) == '0);
    end else if (cen_i) begin
      strobe_q <= (cnt_d_i == target);
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/ika9958_hdot_timing.sv
// Horizontal dot counter, HBLANK/HSYNC set/reset strobes and their NOR-style level latches.
// Horizontal set-adjust from i_HADJ is enabled by defining IKA9958_HADJ_EN.
module ika9958_hdot_timing
  import ika9958_pkg::*;
#(
  parameter int HTOTAL     = 342,
  parameter int CNT_W      = HCNT_W,
  parameter int HBLANK_SET = 256,
  parameter int HBLANK_RST = 0,
  parameter int HSYNC_SET  = 282,
  parameter int HSYNC_RST  = 307
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_CEN,
  input  logic [3:0]       i_HADJ,
  output logic [CNT_W-1:0] o_HCNT,
  output logic             o_LINE_END,
  output logic             o_HBLANK_S,
  output logic             o_HBLANK_R,
  output logic             o_HSYNC_S,
  output logic             o_HSYNC_R,
  output logic             o_HBLANK,
  output logic             o_HSYNC
);

  hcnt_t cnt_q, cnt_d;
  hadj_t adj_q, adj_d;
  logic  wrap;
  logic  line_end_q, blank_q, sync_q;

  assign wrap  = (cnt_q == hcnt_t'(HTOTAL - 1));
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

`ifdef IKA9958_HADJ_EN
  // The new adjust takes effect with the first dot of the next line.
  assign adj_d = wrap ? hadj_t'(i_HADJ) : adj_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      adj_q <= '0;
    end else if (i_CEN) begin
      adj_q <= adj_d;
    end
  end
`else
  logic unused_hadj;
  assign unused_hadj = ^i_HADJ;
  assign adj_q       = '0;
  assign adj_d       = '0;
`endif

  ika9958_hdot_cmp #(.BASE(HBLANK_SET), .HTOTAL(HTOTAL)) u_blank_s (
    .clk_i(i_CLK), .rst_i(i_RST), .cen_i(i_CEN), .adj_d_i(adj_d), .cnt_d_i(cnt_d), .strobe_o(o_HBLANK_S)
  );
  ika9958_hdot_cmp #(.BASE(HBLANK_RST), .HTOTAL(HTOTAL)) u_blank_r (
    .clk_i(i_CLK), .rst_i(i_RST), .cen_i(i_CEN), .adj_d_i(adj_d), .cnt_d_i(cnt_d), .strobe_o(o_HBLANK_R)
  );
  ika9958_hdot_cmp #(.BASE(HSYNC_SET), .HTOTAL(HTOTAL)) u_sync_s (
    .clk_i(i_CLK), .rst_i(i_RST), .cen_i(i_CEN), .adj_d_i(adj_d), .cnt_d_i(cnt_d), .strobe_o(o_HSYNC_S)
  );
  ika9958_hdot_cmp #(.BASE(HSYNC_RST), .HTOTAL(HTOTAL)) u_sync_r (
    .clk_i(i_CLK), .rst_i(i_RST), .cen_i(i_CEN), .adj_d_i(adj_d), .cnt_d_i(cnt_d), .strobe_o(o_HSYNC_R)
  );

  // NOTE: non-blocking assignments keep every level latch reading last dot's strobes.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      cnt_q      <= '0;
      line_end_q <= 1'b0;
      blank_q    <= 1'b1;
      sync_q     <= 1'b0;
    end else if (i_CEN) begin
      cnt_q      <= cnt_d;
      line_end_q <= (cnt_d == hcnt_t'(HTOTAL - 1));
      // Reset dominates when set and reset targets coincide.
      if (o_HBLANK_R)      blank_q <= 1'b0;
      else if (o_HBLANK_S) blank_q <= 1'b1;
      if (o_HSYNC_R)       sync_q  <= 1'b0;
      else if (o_HSYNC_S)  sync_q  <= 1'b1;
    end
  end

  assign o_HCNT     = cnt_q;
  assign o_LINE_END = line_end_q;
  assign o_HBLANK   = blank_q;
  assign o_HSYNC    = sync_q;

endmodule

// File: doc/ika9958_hdot_timing.md
Name: ika9958_hdot_timing

Overview:
- Horizontal dot-timing generator for the VDP video pipeline. It sits directly upstream of the set/reset latch primitives.
- Runs the per-line dot counter and decodes it into one-dot-wide set/reset strobes for HBLANK and HSYNC.
- Latches those strobes into level outputs with NOR-latch semantics, so downstream latch stages and the video output stage see consistent timing.
- Horizontal set-adjust (R#18 low nibble) shifts all decode points; the shift is applied only at line boundaries.

Parameters:
- HTOTAL, 342: dots per line; the counter runs 0..HTOTAL-1.
- CNT_W, 9: counter width; HTOTAL must not exceed 2^CNT_W.
- HBLANK_SET, 256: dot at which blanking starts.
- HBLANK_RST, 0: dot at which blanking ends.
- HSYNC_SET, 282: dot at which sync starts.
- HSYNC_RST, 307: dot at which sync ends.

Ports:
- i_CLK      in   1      master clock
- i_RST      in   1      synchronous reset, active-high
- i_CEN      in   1      dot clock enable; all state advances only on i_CLK edges with i_CEN=1
- i_HADJ     in   4      signed horizontal adjust, -8..+7 dots
- o_HCNT     out  CNT_W  current dot count
- o_LINE_END out  1      high for the whole dot in which o_HCNT==HTOTAL-1
- o_HBLANK_S out  1      set strobe; high while o_HCNT==blank-set target
- o_HBLANK_R out  1      reset strobe; high while o_HCNT==blank-reset target
- o_HSYNC_S  out  1      set strobe; high while o_HCNT==sync-set target
- o_HSYNC_R  out  1      reset strobe; high while o_HCNT==sync-reset target
- o_HBLANK   out  1      latched blank level, active-high
- o_HSYNC    out  1      latched sync level, active-high

Behaviour:
- Reset (i_RST=1 on an i_CLK edge, independent of i_CEN):
  - o_HCNT=0, adjust shadow=0.
  - Strobes recomputed for count 0, so o_HBLANK_R=1 with default parameters.
  - o_HBLANK=1, o_HSYNC=0, o_LINE_END=0.
  - Reset asserted mid-line: the next cycle shows count 0; no partial strobes are held over.
- Counter, on an i_CEN edge:
  - cnt <= (cnt==HTOTAL-1) ? 0 : cnt+1.
  - i_CEN=0: all outputs hold, including strobes.
- Adjust shadow:
  - Loaded from i_HADJ on the i_CEN edge where cnt wraps to 0.
  - Mid-line changes of i_HADJ have no effect until the next line.
- Target computation: for each base B, target = B + sext(adj), wrapped modulo HTOTAL.
  - If the sum is < 0, add HTOTAL.
  - If the sum is ≥ HTOTAL, subtract HTOTAL.
  - Compute with CNT_W+1 signed bits.
- Strobes:
  - Registered together with the counter, computed from the next count value.
  - Each strobe is therefore high for exactly one dot: the dot in which o_HCNT equals its target.
  - o_LINE_END is computed the same way.
- Level latches:
  - Updated on i_CEN edges from the current strobes, one dot after the strobe.
  - S=1,R=0 → level 1. S=0,R=1 → level 0. S=R=0 → hold.
  - S=R=1 (coincident targets) → level 0; reset dominates.
- Latency: a strobe at dot n produces its level change visible at dot n+1.
- Wrap-around dot HTOTAL-1 → 0 requires no special casing.

Optional Feature:
- Macro: IKA9958_HADJ_EN.
- Defined: the i_HADJ path is active as specified above.
- Undefined:
  - Adjust shadow is tied to 0, and i_HADJ is left unconnected internally.
  - Targets equal the raw parameters; wrap arithmetic is removed.
  - The port remains present for interface stability.

Decomposition:
- Package ika9958_pkg holds:
  - typedef hcnt_t (logic [CNT_W-1:0]) and the signed adjust typedef hadj_t (logic signed [3:0]).
  - Function hwrap(base, adj) returning the wrapped target.
- Natural sub-module: ika9958_hdot_cmp. It takes a base parameter, the shadow adjust, and the next count, and outputs a registered strobe. It is instantiated four times.
- Level latches stay inline.

Test Plan:
- Reset: hold i_RST 2 cycles with i_CEN=1 → o_HCNT=0, o_HBLANK=1, o_HSYNC=0, o_HBLANK_R=1, o_LINE_END=0.
- Free-run, adj=0:
  - o_HSYNC_S high only at HCNT=282; o_HSYNC=1 for HCNT 283..307 and 0 from HCNT 308.
  - o_HBLANK=1 for HCNT 257..341 and 0..0, then 0 from HCNT 1.
  - o_LINE_END only at HCNT 341.
- Adjust: set i_HADJ=-8 at HCNT 100.
  - Current line unchanged.
  - Next line: o_HBLANK_R at HCNT 334 (wrap) and o_HSYNC_S at 274.
  - With the macro undefined: o_HBLANK_R stays at HCNT 0 and o_HSYNC_S stays at 282.
- Enable gating: i_CEN=1 every 3rd cycle → each strobe spans 3 i_CLK cycles; o_HSYNC toggles once per event.
- Mid-line reset: assert i_RST at HCNT 150 while o_HSYNC=0 → next cycle HCNT=0, o_HBLANK=1, and the shadow adjust returns to 0.
- Coincident targets: HSYNC_SET=HSYNC_RST=290 → both strobes at HCNT 290 and o_HSYNC stays 0 for the whole line.
